// File: rtl/zx_kbd_pkg.sv
// Shared types and constants for the PS/2 to ZX Spectrum keyboard front end.
// Holds the decoder state encoding, the special scancodes and the matrix geometry.
package zx_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } dec_state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_OVF0  = 8'h00;
  localparam logic [7:0] SC_OVF1  = 8'hFF;

  localparam int ROWS = 8;
  localparam int COLS = 5;

endpackage

// File: rtl/zx_keymap.sv
// Combinational set-2 scancode to ZX matrix position lookup.
// Extended (E0-prefixed) keys never reach this table as mapped keys.
module zx_keymap (
  input  logic [7:0] scan_code,
  output logic       hit,
  output logic [2:0] row,
  output logic [2:0] col
);

  logic [5:0] pos;

  // Each octal literal is {row, col}, so 6'o73 means row 7, column 3.
  always_comb begin
    hit = 1'b1;
    pos = 6'o00;
    case (scan_code)
      8'h12: pos = 6'o00;
      8'h1A: pos = 6'o01;
      8'h22: pos = 6'o02;
      8'h21: pos = 6'o03;
      8'h2A: pos = 6'o04;
      8'h1C: pos = 6'o10;
      8'h1B: pos = 6'o11;
      8'h23: pos = 6'o12;
      8'h2B: pos = 6'o13;
      8'h34: pos = 6'o14;
      8'h15: pos = 6'o20;
      8'h1D: pos = 6'o21;
      8'h24: pos = 6'o22;
      8'h2D: pos = 6'o23;
      8'h2C: pos = 6'o24;
      8'h16: pos = 6'o30;
      8'h1E: pos = 6'o31;
      8'h26: pos = 6'o32;
      8'h25: pos = 6'o33;
      8'h2E: pos = 6'o34;
      8'h45: pos = 6'o40;
      8'h46: pos = 6'o41;
      8'h3E: pos = 6'o42;
      8'h3D: pos = 6'o43;
      8'h36: pos = 6'o44;
      8'h4D: pos = 6'o50;
      8'h44: pos = 6'o51;
      8'h43: pos = 6'o52;
      8'h3C: pos = 6'o53;
      8'h35: pos = 6'o54;
      8'h5A: pos = 6'o60;
      8'h4B: pos = 6'o61;
      8'h42: pos = 6'o62;
      8'h3B: pos = 6'o63;
      8'h33: pos = 6'o64;
      8'h29: pos = 6'o70;
      8'h59: pos = 6'o71;
      8'h3A: pos = 6'o72;
      8'h31: pos = 6'o73;
      8'h32: pos = 6'o74;
      default: hit = 1'b0;
    endcase
  end

  assign row = pos[5:3];
  assign col = pos[2:0];

endmodule

// File: rtl/ps2_zx_keyboard.sv
// PS/2 receiver, set-2 make/break decoder and ZX 8x5 key matrix feeding the
// active-low column word of the Z80 port-0xFE read.
module ps2_zx_keyboard
  import zx_kbd_pkg::*;
#(
  parameter int TIMEOUT     = 20000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] addr_hi,
  output logic [4:0] kbd_data,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       rx_error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;

  dec_state_t state, next_state;
  logic       set_key, clr_key, clr_all;
  logic       map_hit;
  logic [2:0] map_row, map_col;

  logic [ROWS-1:0][COLS-1:0] key_mat;
  logic [COLS-1:0]           col_or;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

  // Bit 0 is the start bit, 1..8 data, 9 parity, 10 stop; strobes land one cycle after the stop edge.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      bit_cnt    <= 4'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      scan_valid <= 1'b0;
      rx_error   <= 1'b0;
      scan_code  <= 8'h00;
    end else begin
      scan_valid <= 1'b0;
      rx_error   <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (!dat_s) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {dat_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par_bit <= dat_s;
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if ((^{shreg, par_bit}) && dat_s) begin
            scan_valid <= 1'b1;
            scan_code  <= shreg;
          end else begin
            rx_error <= 1'b1;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (tcnt == TW'(TIMEOUT - 1)) begin
          tcnt    <= '0;
          bit_cnt <= 4'd0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  zx_keymap u_keymap (
    .scan_code (scan_code),
    .hit       (map_hit),
    .row       (map_row),
    .col       (map_col)
  );

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    set_key    = 1'b0;
    clr_key    = 1'b0;
    clr_all    = 1'b0;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (scan_code == SC_BREAK)                            next_state = BRK;
          else if (scan_code == SC_EXT)                         next_state = EXT;
          else if (scan_code == SC_OVF0 || scan_code == SC_OVF1) clr_all   = 1'b1;
          else if (map_hit)                                     set_key    = 1'b1;
        end
        BRK: begin
          clr_key    = map_hit;
          next_state = IDLE;
        end
        EXT:     next_state = (scan_code == SC_BREAK) ? EXT_BRK : IDLE;
        EXT_BRK: next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      key_mat <= '0;
    end else if (clr_all) begin
      key_mat <= '0;
    end else if (set_key) begin
      key_mat[map_row][map_col] <= 1'b1;
    end else if (clr_key) begin
      key_mat[map_row][map_col] <= 1'b0;
    end
  end

  // A row takes part in the read when its address line is low.
  always_comb begin
    col_or = '0;
    for (int k = 0; k < ROWS; k++) begin
      if (!addr_hi[k]) col_or = col_or | key_mat[k];
    end
    kbd_data = ~col_or;
  end

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Self-checking bench for ps2_zx_keyboard: directed frames plus a randomized
// scancode stream, compared against a key-table model of the ZX matrix.
module tb_ps2_zx_keyboard;

  localparam int TIMEOUT = 20000;
  localparam int HALF    = 8;
  localparam int M_IDLE = 0, M_BRK = 1, M_EXT = 2, M_EXT_BRK = 3;

  logic       clk = 1'b0;
  logic       nRESET = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] addr_hi = 8'h00;
  logic [4:0] kbd_data;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       rx_error;

  int tests_run = 0;
  int tests_failed = 0;
  int valid_seen = 0;
  int err_seen = 0;
  int exp_valid = 0;
  int exp_err = 0;
  logic [7:0] exp_code = 8'h00;
  int dec_mode = M_IDLE;
  bit pressed [40];

  // Matrix position i is row i/5, column i%5.
  logic [7:0] key_codes [40] = '{
    8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A,
    8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
    8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
    8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
    8'h29, 8'h59, 8'h3A, 8'h31, 8'h32
  };

  ps2_zx_keyboard #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .nRESET     (nRESET),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .addr_hi    (addr_hi),
    .kbd_data   (kbd_data),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .rx_error   (rx_error)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    if (scan_valid) valid_seen++;
    if (rx_error)   err_seen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int findKey(input logic [7:0] code);
    for (int i = 0; i < 40; i++) if (key_codes[i] == code) return i;
    return -1;
  endfunction

  function automatic logic [4:0] modelRead(input logic [7:0] addr);
    logic [4:0] r = 5'b11111;
    for (int i = 0; i < 40; i++)
      if (pressed[i] && !addr[i / 5]) r[i % 5] = 1'b0;
    return r;
  endfunction

  task automatic modelDecode(input logic [7:0] code);
    int idx = findKey(code);
    case (dec_mode)
      M_IDLE: begin
        if (code == 8'hF0)                    dec_mode = M_BRK;
        else if (code == 8'hE0)               dec_mode = M_EXT;
        else if (code == 8'h00 || code == 8'hFF)
          for (int i = 0; i < 40; i++) pressed[i] = 1'b0;
        else if (idx >= 0)                    pressed[idx] = 1'b1;
      end
      M_BRK: begin
        if (idx >= 0) pressed[idx] = 1'b0;
        dec_mode = M_IDLE;
      end
      M_EXT:   dec_mode = (code == 8'hF0) ? M_EXT_BRK : M_IDLE;
      default: dec_mode = M_IDLE;
    endcase
  endtask

  task automatic sendBits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ps2_dat = frame[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
  endfunction

  task automatic applyStimulus(input logic [7:0] code, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    sendBits(makeFrame(code, bad_par, bad_stop), 11);
    repeat (6) @(negedge clk);
    if (!bad_par && !bad_stop) begin
      exp_valid++;
      exp_code = code;
      modelDecode(code);
    end else begin
      exp_err++;
    end
    checkOutput("valid_pulses", valid_seen, exp_valid);
    checkOutput("error_pulses", err_seen, exp_err);
    checkOutput("scan_code", {24'h0, scan_code}, {24'h0, exp_code});
  endtask

  task automatic checkKbd(input logic [7:0] addr, input logic [4:0] expected);
    @(negedge clk) addr_hi = addr;
    #1 checkOutput($sformatf("kbd_data@%02h", addr), {27'h0, kbd_data}, {27'h0, expected});
  endtask

  initial begin
    logic [7:0] code;
    logic [7:0] addr;
    int r;

    #1;
    checkOutput("rst_kbd_data", {27'h0, kbd_data}, 32'h1F);
    checkOutput("rst_scan_code", {24'h0, scan_code}, 32'h0);
    checkOutput("rst_scan_valid", {31'h0, scan_valid}, 32'h0);
    checkOutput("rst_rx_error", {31'h0, rx_error}, 32'h0);
    repeat (4) @(negedge clk);
    nRESET = 1'b1;
    repeat (6) @(negedge clk);

    applyStimulus(8'h1C);
    checkKbd(8'hFD, 5'b11110);
    checkKbd(8'hFE, 5'b11111);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    checkKbd(8'hFD, 5'b11111);

    applyStimulus(8'h12);
    applyStimulus(8'h1A);
    checkKbd(8'hFE, 5'b11100);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    checkKbd(8'hFE, 5'b11101);

    applyStimulus(8'h29, 1'b1, 1'b0);
    checkKbd(8'h7F, 5'b11111);
    applyStimulus(8'h29, 1'b0, 1'b1);
    checkKbd(8'h7F, 5'b11111);

    sendBits(makeFrame(8'h3A, 1'b0, 1'b0), 6);
    repeat (TIMEOUT + 10) @(negedge clk);
    applyStimulus(8'h5A);
    checkKbd(8'hBF, 5'b11110);

    // A lone falling edge with data high is not a start bit.
    sendBits(11'h7FF, 1);
    repeat (6) @(negedge clk);
    applyStimulus(8'h1B);
    checkKbd(8'hFD, 5'b11101);

    applyStimulus(8'h1C);
    applyStimulus(8'h29);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    checkKbd(8'hFD, 5'b11100);
    checkKbd(8'h7F, 5'b11110);
    applyStimulus(8'hFF);
    checkKbd(8'h00, 5'b11111);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      code = key_codes[$urandom_range(0, 39)];
      else if (r < 65) code = 8'hF0;
      else if (r < 72) code = 8'hE0;
      else if (r < 75) code = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      else             code = 8'($urandom);
      applyStimulus(code, (r >= 92 && r < 97), (r >= 97));
      addr = (n % 4 == 0) ? 8'h00 : 8'($urandom);
      checkKbd(addr, modelRead(addr));
    end

    applyStimulus(8'hF0);
    applyStimulus(8'hF0);
    applyStimulus(8'h45);
    applyStimulus(8'h32);
    checkKbd(8'h00, modelRead(8'h00));
    sendBits(makeFrame(8'h16, 1'b0, 1'b0), 4);
    @(negedge clk);
    #5 nRESET = 1'b0;
    #1;
    checkOutput("midrst_kbd_data", {27'h0, kbd_data}, 32'h1F);
    checkOutput("midrst_scan_code", {24'h0, scan_code}, 32'h0);
    checkOutput("midrst_scan_valid", {31'h0, scan_valid}, 32'h0);
    checkOutput("midrst_rx_error", {31'h0, rx_error}, 32'h0);
    for (int i = 0; i < 40; i++) pressed[i] = 1'b0;
    dec_mode = M_IDLE;
    exp_code = 8'h00;
    repeat (3) @(negedge clk);
    nRESET = 1'b1;
    repeat (6) @(negedge clk);
    applyStimulus(8'h1A);
    checkKbd(8'hFE, 5'b11101);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_zx_keyboard.md
Name: ps2_zx_keyboard

Overview:
- Keyboard front end for the Z80 port-0xFE read path.
- Receives PS/2 device-to-host frames and decodes set-2 make/break codes into a ZX 8x5 key matrix.
- Returns the active-low 5-bit column word for the row(s) selected by the Z80 upper address byte.
- The top level drives D[4:0] from kbd_data on IORQ reads with A[0]=0; D[7:5] are handled at the top.

Parameters:
- TIMEOUT, 20000, clk cycles without a PS/2 falling edge before a partial frame is aborted.
- SYNC_STAGES, 2, synchronizer flops on ps2_clk and ps2_dat.

Ports:
- clk  in  1  system clock (25 MHz domain).
- nRESET  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- ps2_dat  in  1  raw PS/2 data line (asynchronous).
- addr_hi  in  8  Z80 A[15:8]; bit k=0 selects matrix row k.
- kbd_data  out  5  active-low column bits, AND of all selected rows.
- scan_valid  out  1  one-cycle strobe when a frame is received without error.
- scan_code  out  8  last good byte; held until the next good frame.
- rx_error  out  1  one-cycle strobe on a parity or stop-bit error.

Behaviour:
Reset:
- All flops clear asynchronously on nRESET=0.
- Matrix all released; kbd_data=5'b11111; scan_code=8'h00; scan_valid=0; rx_error=0.
- Both FSMs go to their IDLE state.
- A reset mid-frame discards the partial frame.

Receiver:
- ps2_clk and ps2_dat pass through SYNC_STAGES flops.
- A falling edge is detected from the last two ps2_clk samples. Data is sampled on that cycle.
- Frame format: start(0), 8 data bits LSB first, odd parity, stop(1).
- Bit counter runs 0..10.
- Start bit read as 1: stay idle; no error strobe.
- After the stop bit, exactly one of the following occurs in the next clk cycle:
  - parity odd and stop=1: scan_valid=1 and scan_code updated;
  - otherwise: rx_error=1 and scan_code unchanged.
- Timeout counter resets on every falling edge. If it reaches TIMEOUT with bit counter ≠0, the counter returns to 0 and nothing is strobed.

Decoder FSM:
- Advances only on scan_valid. States: IDLE, BRK, EXT, EXT_BRK.
- IDLE:
  - F0→BRK; E0→EXT.
  - 00 or FF (overflow/error): release all keys, stay IDLE.
  - Mapped code: set that key pressed.
  - Other codes: ignored.
- BRK: mapped code releases that key; any byte→IDLE.
- EXT: F0→EXT_BRK; any other byte is discarded and returns to IDLE.
- EXT_BRK: any byte→IDLE. Extended keys are not mapped.
- Press of an already-pressed key and release of a released key are no-ops.
- Matrix is a 40-bit register, 1=pressed, updated one cycle after scan_valid.

Key map (row: col0..col4):
- r0: CAPS(12 LShift) Z(1A) X(22) C(21) V(2A)
- r1: A(1C) S(1B) D(23) F(2B) G(34)
- r2: Q(15) W(1D) E(24) R(2D) T(2C)
- r3: 1(16) 2(1E) 3(26) 4(25) 5(2E)
- r4: 0(45) 9(46) 8(3E) 7(3D) 6(36)
- r5: P(4D) O(44) I(43) U(3C) Y(35)
- r6: ENTER(5A) L(4B) K(42) J(3B) H(33)
- r7: SPACE(29) SYM(59 RShift) M(3A) N(31) B(32)

Read port:
- Combinational from the matrix register: kbd_data[c] = ~OR over k (addr_hi[k]==0 & key[k][c]).
- addr_hi=8'hFF gives 5'b11111.
- addr_hi=8'h00 ORs all rows.

Decomposition:
- Package zx_kbd_pkg holds:
  - decoder state enum (IDLE, BRK, EXT, EXT_BRK);
  - constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_OVF0=8'h00, SC_OVF1=8'hFF;
  - ROWS=8, COLS=5.
- Sub-module zx_keymap: combinational scancode → {hit, row[2:0], col[2:0]}.
- Receiver, FSM, matrix and read logic stay in ps2_zx_keyboard.

Test Plan:
- Send frame 1C (parity bit 0) → scan_valid pulse, scan_code=1C. addr_hi=FD gives kbd_data=5'b11110; addr_hi=FE gives 5'b11111.
- Send F0,1C → key A released. addr_hi=FD gives kbd_data=5'b11111. No rx_error.
- Send 12 then 1A → addr_hi=FE gives kbd_data=5'b11100. Send F0,12 → 5'b11101.
- Send 29 with parity bit flipped → rx_error pulse, no scan_valid, scan_code unchanged, matrix unchanged.
- Send 6 bits of a frame, wait TIMEOUT+10 cycles, then send full frame 5A → only 5A accepted. addr_hi=BF gives 5'b11110.
- Press 1C, 5A, 29. Send E0,F0,1C → A stays pressed. Send FF → addr_hi=00 gives 5'b11111. Assert nRESET mid-frame → all outputs at reset values on the same cycle.
